sseg_scan_decoder: RTL
======================

Name: sseg_scan_decoder

Overview:
- Receiving end of the 4-digit multiplexed seven-segment interface that the display driver (an/sseg) produces.
- Samples the time-multiplexed anode and segment lines and reconstructs the four displayed hex digits plus decimal points.
- Flags unrecognised glyphs and publishes a coherent frame once every digit has been captured.
- Used as an on-chip monitor and as a self-checking bench component for the display-driven test designs.

Parameters:
- STABLE_CYCLES, 4: consecutive identical samples of an/sseg required before a digit is captured; minimum 1.
- TIMEOUT_CYCLES, 262144: cycles with no capture before the frame is declared stale.

Ports:
- clk_amisha  in  1  system clock
- reset_amisha  in  1  reset
- an_amisha  in  4  anode enables, active-low, bit i = digit i
- sseg_amisha  in  8  segments, active-low; [7]=dp, [6:0]=g,f,e,d,c,b,a
- hex_amisha  out  16  decoded digits {d3,d2,d1,d0}, 4 bits each
- dp_amisha  out  4  decimal point per digit, 1 = lit
- blank_amisha  out  4  digit had all segments off
- err_amisha  out  4  digit pattern not a valid hex glyph
- frame_valid_amisha  out  1  outputs hold a complete, non-stale frame
- frame_tick_amisha  out  1  one-cycle pulse on each frame commit
- timeout_amisha  out  1  no capture for TIMEOUT_CYCLES

Behaviour:
- Interface: one clock; reset is asynchronous and active-high (clk_amisha, reset_amisha).
- Reset values: all outputs 0, shadow registers 0, seen mask 0, FSM in TRACK.
- Sampling: the (an, sseg) pair is registered each cycle. stable_cnt clears when the sample differs from the previous sample; otherwise it increments, saturating.
- Capture qualifier: the pair has been identical for STABLE_CYCLES consecutive cycles AND an has exactly one bit low.
- an = 4'b1111 (inter-digit blanking) or multiple bits low: never captured; stable_cnt still tracks.
- FSM TRACK: on the capture qualifier, write glyph decode, dp, blank and err into digit-i shadow; set seen[i]; go to HOLD.
- FSM HOLD: on the first cycle the sample differs, return to TRACK. Prevents re-capturing the same dwell.
- Recapture of an already-seen digit before the frame completes overwrites its shadow; the latest value wins.
- Frame commit: when seen becomes 4'b1111, on the next clock copy the shadows to the outputs, pulse frame_tick for one cycle, set frame_valid, clear seen. Latency from the final capture to outputs is 1 cycle.
- Glyph decode, sseg[6:0] active-low:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000
  - 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110
  - 1111111 gives hex 0, blank=1.
  - Any other pattern gives hex 0, err=1.
  - dp = ~sseg[7].
- Timeout: counter clears on every capture and otherwise increments. At TIMEOUT_CYCLES it sets timeout=1, clears frame_valid and seen; hex/dp/blank/err hold their last values.
- timeout clears on the next capture.
- Capture and timeout in the same cycle: capture wins, counter clears.
- Asynchronous reset mid-frame discards all partial shadows immediately.

Optional Feature:
- Macro: SSEG_SYNC_EN.
- Defined: a 2-flop synchroniser sits on an_amisha and sseg_amisha ahead of the sample register. Every latency grows by 2 cycles. The synchroniser flops reset to an=4'b1111, sseg=8'hFF.
- Undefined: inputs are registered once and assumed to be in the clk_amisha domain.

Decomposition:
- Package sseg_pkg holds:
  - the 16 glyph constants and the blank constant
  - the state enum (TRACK, HOLD)
  - a digit-index-from-onehot-low function
  - a width constant for the digit nibble
- One sub-module, sseg_glyph_decoder: combinational, 7-bit pattern in, hex/blank/err out. Instantiated once on the sample path.

Test Plan:
- Drive the digit sequence an=1110/1101/1011/0111 with glyphs 3,0,A,F, each held 8 cycles with STABLE_CYCLES=4 -> hex=16'hFA03, err=0, frame_tick single pulse, frame_valid=1.
- Digit 0 sseg=8'b0_1000000, others blank (8'hFF) -> dp=4'b0001, blank=4'b1110, hex=16'h0000.
- Digit 2 pattern 7'b1010101 -> err=4'b0100, hex[11:8]=0; other digits decode normally.
- Each digit held only 3 cycles (< STABLE_CYCLES) -> no capture, frame_tick never pulses, frame_valid stays 0.
- Complete a frame, then hold an=4'b1111 for TIMEOUT_CYCLES (set to 64) -> timeout=1 at cycle 64, frame_valid=0, hex unchanged. Next valid digit clears timeout.
- Assert reset after 2 digits captured, then complete 4 new digits -> first frame_tick only after all 4 post-reset captures; an=0011 (two low) is never captured.

Source files
------------

// File: rtl/sseg_pkg.sv
// sseg_pkg: shared constants, state type and helpers for the seven-segment
// scan decoder (glyph patterns are active-low, bit order g,f,e,d,c,b,a).
package sseg_pkg;

   localparam int NIB_W = 4;

   localparam logic [6:0] GLYPH_0     = 7'b1000000;
   localparam logic [6:0] GLYPH_1     = 7'b1111001;
   localparam logic [6:0] GLYPH_2     = 7'b0100100;
   localparam logic [6:0] GLYPH_3     = 7'b0110000;
   localparam logic [6:0] GLYPH_4     = 7'b0011001;
   localparam logic [6:0] GLYPH_5     = 7'b0010010;
   localparam logic [6:0] GLYPH_6     = 7'b0000010;
   localparam logic [6:0] GLYPH_7     = 7'b1111000;
   localparam logic [6:0] GLYPH_8     = 7'b0000000;
   localparam logic [6:0] GLYPH_9     = 7'b0010000;
   localparam logic [6:0] GLYPH_A     = 7'b0001000;
   localparam logic [6:0] GLYPH_B     = 7'b0000011;
   localparam logic [6:0] GLYPH_C     = 7'b1000110;
   localparam logic [6:0] GLYPH_D     = 7'b0100001;
   localparam logic [6:0] GLYPH_E     = 7'b0000110;
   localparam logic [6:0] GLYPH_F     = 7'b0001110;
   localparam logic [6:0] GLYPH_BLANK = 7'b1111111;

   typedef enum logic [0:0] {
      TRACK = 1'b0,
      HOLD  = 1'b1
   } state_t;

   // Digit index of the single active-low anode; 0 when the pattern is not one-hot-low
   function automatic logic [1:0] digit_idx(input logic [3:0] an);
      logic [1:0] idx;
      case (an)
         4'b1110: idx = 2'd0;
         4'b1101: idx = 2'd1;
         4'b1011: idx = 2'd2;
         4'b0111: idx = 2'd3;
         default: idx = 2'd0;
      endcase
      return idx;
   endfunction

   // True when exactly one anode is driven low
   function automatic logic is_onehot_low(input logic [3:0] an);
      logic ok;
      case (an)
         4'b1110, 4'b1101, 4'b1011, 4'b0111: ok = 1'b1;
         default:                            ok = 1'b0;
      endcase
      return ok;
   endfunction

endpackage

// File: rtl/sseg_glyph_decoder.sv
// sseg_glyph_decoder: combinational map from an active-low segment pattern
// back to its hex value, flagging all-off (blank) and unknown (err) patterns.
module sseg_glyph_decoder
   import sseg_pkg::*;
(
   input  logic [6:0]       pattern,
   output logic [NIB_W-1:0] hex,
   output logic             blank,
   output logic             err
);

   // Reverse glyph lookup; anything unlisted is reported as an error with hex 0
   always_comb begin
      hex   = 4'h0;
      blank = 1'b0;
      err   = 1'b0;
      case (pattern)
         GLYPH_0:     hex = 4'h0;
         GLYPH_1:     hex = 4'h1;
         GLYPH_2:     hex = 4'h2;
         GLYPH_3:     hex = 4'h3;
         GLYPH_4:     hex = 4'h4;
         GLYPH_5:     hex = 4'h5;
         GLYPH_6:     hex = 4'h6;
         GLYPH_7:     hex = 4'h7;
         GLYPH_8:     hex = 4'h8;
         GLYPH_9:     hex = 4'h9;
         GLYPH_A:     hex = 4'hA;
         GLYPH_B:     hex = 4'hB;
         GLYPH_C:     hex = 4'hC;
         GLYPH_D:     hex = 4'hD;
         GLYPH_E:     hex = 4'hE;
         GLYPH_F:     hex = 4'hF;
         GLYPH_BLANK: blank = 1'b1;
         default:     err = 1'b1;
      endcase
   end

endmodule

// File: rtl/sseg_scan_decoder.sv
// sseg_scan_decoder: samples a 4-digit multiplexed seven-segment bus, captures
// each digit once it has dwelt long enough, and publishes a coherent frame when
// all four digits have been seen. A stale-frame timeout drops frame_valid.
// Optional: define SSEG_SYNC_EN to place a 2-flop synchroniser on an/sseg.
module sseg_scan_decoder
   import sseg_pkg::*;
#(
   parameter int STABLE_CYCLES  = 4,
   parameter int TIMEOUT_CYCLES = 262144
) (
   input  logic        clk_amisha,
   input  logic        reset_amisha,
   input  logic [3:0]  an_amisha,
   input  logic [7:0]  sseg_amisha,
   output logic [15:0] hex_amisha,
   output logic [3:0]  dp_amisha,
   output logic [3:0]  blank_amisha,
   output logic [3:0]  err_amisha,
   output logic        frame_valid_amisha,
   output logic        frame_tick_amisha,
   output logic        timeout_amisha
);

   localparam int              ST_W    = $clog2(STABLE_CYCLES + 1);
   localparam int              TO_W    = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [ST_W-1:0] ST_MAX  = ST_W'(STABLE_CYCLES);
   localparam logic [ST_W-1:0] ST_QUAL = ST_W'(STABLE_CYCLES - 1);
   localparam logic [TO_W-1:0] TO_MAX  = TO_W'(TIMEOUT_CYCLES);
   localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

   logic [11:0]            raw_s;
   logic [11:0]            sample_r;
   logic [ST_W-1:0]        stable_cnt_r;
   logic [3:0]             an_s;
   logic [7:0]             sseg_s;
   logic [NIB_W-1:0]       dec_hex_s;
   logic                   dec_blank_s;
   logic                   dec_err_s;
   logic [1:0]             idx_s;
   logic                   changed_s;
   logic                   capture_s;
   logic                   commit_s;
   logic                   to_fire_s;
   state_t                 state_r;
   state_t                 state_nx_s;
   logic [3:0]             seen_r;
   logic [3:0]             seen_nx_s;
   logic [3:0][NIB_W-1:0]  shd_hex_r;
   logic [3:0]             shd_dp_r;
   logic [3:0]             shd_blank_r;
   logic [3:0]             shd_err_r;
   logic [TO_W-1:0]        to_cnt_r;
   logic [15:0]            hex_r;
   logic [3:0]             dp_r;
   logic [3:0]             blank_r;
   logic [3:0]             err_r;
   logic                   frame_valid_r;
   logic                   frame_tick_r;
   logic                   timeout_r;

`ifdef SSEG_SYNC_EN
   logic [11:0] sync1_r;
   logic [11:0] sync2_r;

   // Two-flop synchroniser; idles at "all anodes off, all segments off"
   always_ff @(posedge clk_amisha or posedge reset_amisha) begin
      if (reset_amisha) begin
         sync1_r <= 12'hFFF;
         sync2_r <= 12'hFFF;
      end else begin
         sync1_r <= {an_amisha, sseg_amisha};
         sync2_r <= sync1_r;
      end
   end

   assign raw_s = sync2_r;
`else
   assign raw_s = {an_amisha, sseg_amisha};
`endif

   // Register the bus pair and count how many cycles it has stayed unchanged
   always_ff @(posedge clk_amisha or posedge reset_amisha) begin
      if (reset_amisha) begin
         sample_r     <= 12'hFFF;
         stable_cnt_r <= {ST_W{1'b0}};
      end else begin
         sample_r <= raw_s;
         if (raw_s != sample_r) begin
            stable_cnt_r <= {ST_W{1'b0}};
         end else if (stable_cnt_r != ST_MAX) begin
            stable_cnt_r <= stable_cnt_r + ST_W'(1);
         end else begin
            stable_cnt_r <= stable_cnt_r;
         end
      end
   end

   assign an_s      = sample_r[11:8];
   assign sseg_s    = sample_r[7:0];
   assign idx_s     = digit_idx(an_s);
   assign changed_s = (stable_cnt_r == {ST_W{1'b0}});
   assign capture_s = (state_r == TRACK) && (stable_cnt_r >= ST_QUAL) && is_onehot_low(an_s);
   assign commit_s  = (seen_r == 4'b1111);
   assign to_fire_s = !capture_s && (to_cnt_r == TO_LAST);

   sseg_glyph_decoder u_glyph (
      .pattern (sseg_s[6:0]),
      .hex     (dec_hex_s),
      .blank   (dec_blank_s),
      .err     (dec_err_s)
   );

   // Next state: capture once per dwell, re-arm as soon as the sample moves
   always_comb begin
      state_nx_s = state_r;
      case (state_r)
         TRACK: begin
            if (capture_s) state_nx_s = HOLD;
            else           state_nx_s = TRACK;
         end
         HOLD: begin
            if (changed_s) state_nx_s = TRACK;
            else           state_nx_s = HOLD;
         end
         default: state_nx_s = TRACK;
      endcase
   end

   // Seen mask: emptied on commit or staleness, then the captured digit is added
   always_comb begin
      seen_nx_s = seen_r;
      if (commit_s || to_fire_s) seen_nx_s = 4'b0000;
      else                       seen_nx_s = seen_r;
      if (capture_s) seen_nx_s = seen_nx_s | ~an_s;
      else           seen_nx_s = seen_nx_s;
   end

   // State and seen-mask registers
   always_ff @(posedge clk_amisha or posedge reset_amisha) begin
      if (reset_amisha) begin
         state_r <= TRACK;
         seen_r  <= 4'b0000;
      end else begin
         state_r <= state_nx_s;
         seen_r  <= seen_nx_s;
      end
   end

   // Shadow slots hold the latest capture of each digit until the frame commits
   always_ff @(posedge clk_amisha or posedge reset_amisha) begin
      if (reset_amisha) begin
         shd_hex_r   <= {(4*NIB_W){1'b0}};
         shd_dp_r    <= 4'b0000;
         shd_blank_r <= 4'b0000;
         shd_err_r   <= 4'b0000;
      end else if (capture_s) begin
         shd_hex_r[idx_s]   <= dec_hex_s;
         shd_dp_r[idx_s]    <= ~sseg_s[7];
         shd_blank_r[idx_s] <= dec_blank_s;
         shd_err_r[idx_s]   <= dec_err_s;
      end
   end

   // Staleness counter: restarts on capture, saturates once the timeout has fired
   always_ff @(posedge clk_amisha or posedge reset_amisha) begin
      if (reset_amisha) begin
         to_cnt_r  <= {TO_W{1'b0}};
         timeout_r <= 1'b0;
      end else if (capture_s) begin
         to_cnt_r  <= {TO_W{1'b0}};
         timeout_r <= 1'b0;
      end else begin
         if (to_cnt_r != TO_MAX) to_cnt_r <= to_cnt_r + TO_W'(1);
         if (to_fire_s)          timeout_r <= 1'b1;
      end
   end

   // Publish shadows on commit; a stale frame keeps its data but loses valid
   always_ff @(posedge clk_amisha or posedge reset_amisha) begin
      if (reset_amisha) begin
         hex_r         <= 16'h0000;
         dp_r          <= 4'b0000;
         blank_r       <= 4'b0000;
         err_r         <= 4'b0000;
         frame_valid_r <= 1'b0;
         frame_tick_r  <= 1'b0;
      end else begin
         frame_tick_r <= commit_s;
         if (commit_s) begin
            hex_r         <= shd_hex_r;
            dp_r          <= shd_dp_r;
            blank_r       <= shd_blank_r;
            err_r         <= shd_err_r;
            frame_valid_r <= 1'b1;
         end else if (to_fire_s) begin
            frame_valid_r <= 1'b0;
         end
      end
   end

   assign hex_amisha         = hex_r;
   assign dp_amisha          = dp_r;
   assign blank_amisha       = blank_r;
   assign err_amisha         = err_r;
   assign frame_valid_amisha = frame_valid_r;
   assign frame_tick_amisha  = frame_tick_r;
   assign timeout_amisha     = timeout_r;

endmodule
